// File: rtl/decode_strobe_seq_pkg.sv
// Shared definitions for the 74x138 strobe sequencer: FSM state encoding,
// phase counter width and small constant helpers.
package decode_strobe_seq_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    // Counter reload value for a phase lasting cyc cycles.
    function automatic logic [CNT_W-1:0] phase_load(input int cyc);
        return CNT_W'(cyc - 1);
    endfunction

    // Phase lengths must fit the 4-bit counter and be at least one cycle.
    function automatic logic param_ok(input int cyc);
        return (cyc >= 1) && (cyc <= 15);
    endfunction

endpackage

// File: rtl/decode_strobe_seq_if.sv
// Sequencer-side handshake plus decoder drive lines of the strobe sequencer.
interface decode_strobe_seq_if;
    logic       req;
    logic [2:0] sel;
    logic       abort;
    logic       rdy;
    logic       busy;
    logic       done;
    logic [2:0] a;
    logic       g1;
    logic       ng2a;
    logic       ng2b;

    modport master (
        output req, sel, abort,
        input  rdy, busy, done, a, g1, ng2a, ng2b
    );

    modport slave (
        input  req, sel, abort,
        output rdy, busy, done, a, g1, ng2a, ng2b
    );
endinterface

// File: rtl/decode_strobe_seq_timer.sv
// Phase timer: loadable 4-bit down-counter that parks at zero and flags it.
module decode_strobe_seq_timer
    import decode_strobe_seq_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load on phase entry, otherwise count down to zero and stop.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/decode_strobe_seq.sv
// Upstream driver for a 74x138 write-unit decoder. Sets up A before the
// enables, strobes the enables for a fixed count, then holds A. A one-entry
// pending slot lets the sequencer post the next select during a strobe.
module decode_strobe_seq
    import decode_strobe_seq_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                clk,
    input  logic                nreset,
    decode_strobe_seq_if.slave  bus
);

    if (!(param_ok(SETUP_CYC) && param_ok(STROBE_CYC) && param_ok(HOLD_CYC))) begin : g_param_err
        $error("decode_strobe_seq: SETUP_CYC, STROBE_CYC and HOLD_CYC must be in 1..15");
    end

    localparam logic [CNT_W-1:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = phase_load(HOLD_CYC);

    state_t           state_r, state_s;
    logic [2:0]       a_r, a_s;
    logic [2:0]       pend_r, pend_s;
    logic             en_r, en_s;
    logic             ng_r;
    logic             rdy_r, rdy_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             zero_s;
    logic             xfer_s;
    logic             hold_fin_s;
    logic             slot_clr_s;
    logic             next_v_s;
    logic [2:0]       next_a_s;

    decode_strobe_seq_timer u_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

    assign xfer_s     = bus.req & rdy_r;
    assign hold_fin_s = (state_r == ST_HOLD) && zero_s;
    // At the end of HOLD a transfer arriving with the slot empty is chained
    // exactly as if it had been waiting in the slot.
    assign next_v_s   = !rdy_r || xfer_s;
    assign next_a_s   = rdy_r ? bus.sel : pend_r;

    // FSM state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, phase timer loads, next address/enable and pending-slot update.
    always_comb begin
        state_s    = state_r;
        a_s        = a_r;
        en_s       = en_r;
        rdy_s      = rdy_r;
        pend_s     = pend_r;
        done_s     = 1'b0;
        load_s     = 1'b0;
        load_val_s = {CNT_W{1'b0}};
        slot_clr_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    a_s        = bus.sel;
                    state_s    = ST_SETUP;
                    load_s     = 1'b1;
                    load_val_s = SETUP_LD;
                end else if (!rdy_r) begin
                    a_s        = pend_r;
                    slot_clr_s = 1'b1;
                    state_s    = ST_SETUP;
                    load_s     = 1'b1;
                    load_val_s = SETUP_LD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (zero_s) begin
                    state_s    = ST_STROBE;
                    en_s       = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = STROBE_LD;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_STROBE: begin
                // Abort cuts the strobe short but still runs a full HOLD.
                if (bus.abort || zero_s) begin
                    state_s    = ST_HOLD;
                    en_s       = 1'b0;
                    load_s     = 1'b1;
                    load_val_s = HOLD_LD;
                end else begin
                    state_s = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (zero_s) begin
                    done_s     = 1'b1;
                    slot_clr_s = !rdy_r;
                    if (next_v_s && (next_a_s == a_r)) begin
                        state_s    = ST_STROBE;
                        en_s       = 1'b1;
                        load_s     = 1'b1;
                        load_val_s = STROBE_LD;
                    end else if (next_v_s) begin
                        a_s        = next_a_s;
                        state_s    = ST_SETUP;
                        load_s     = 1'b1;
                        load_val_s = SETUP_LD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                en_s    = 1'b0;
            end
        endcase

        // A transfer outside IDLE parks in the slot; it wins over a same-cycle clear.
        if (xfer_s && (state_r != ST_IDLE) && !hold_fin_s) begin
            pend_s = bus.sel;
            rdy_s  = 1'b0;
        end else if (slot_clr_s) begin
            rdy_s = 1'b1;
        end else begin
            rdy_s = rdy_r;
        end

        busy_s = (state_s != ST_IDLE) || !rdy_s;
    end

    // Output and pending-slot registers; reset drops the enables immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            a_r    <= 3'd0;
            pend_r <= 3'd0;
            en_r   <= 1'b0;
            ng_r   <= 1'b1;
            rdy_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            a_r    <= a_s;
            pend_r <= pend_s;
            en_r   <= en_s;
            ng_r   <= ~en_s;
            rdy_r  <= rdy_s;
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    assign bus.a    = a_r;
    assign bus.g1   = en_r;
    assign bus.ng2a = ng_r;
    assign bus.ng2b = ng_r;
    assign bus.rdy  = rdy_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_decode_strobe_seq.sv
// Bench for decode_strobe_seq: directed scenarios on a default-parameter
// instance, constrained random traffic on a 3/4/2 instance. Stimulus pushes
// expected strobes and point checks into queues; one monitor process pops
// and compares them at the falling clock edge.
module tb_decode_strobe_seq;

    localparam int S_A = 0, S_G1 = 1, S_NG2A = 2, S_NG2B = 3, S_RDY = 4, S_BUSY = 5, S_DONE = 6;

    typedef struct {
        logic [2:0] addr;
        int         len;
    } strobe_t;

    typedef struct {
        int sig;
        int expv;
    } pchk_t;

    logic clk = 1'b0;
    logic nreset;

    decode_strobe_seq_if bus0();
    decode_strobe_seq_if bus1();

    decode_strobe_seq u_dut0 (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus0)
    );

    decode_strobe_seq #(
        .SETUP_CYC  (3),
        .STROBE_CYC (4),
        .HOLD_CYC   (2)
    ) u_dut1 (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus1)
    );

    always #5 clk = ~clk;

    strobe_t    sb0[$];
    strobe_t    sb1[$];
    pchk_t      pchk_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_done[2] = '{0, 0};
    int         done_cnt[2] = '{0, 0};
    int         tmo_req = 0;
    int         tmo_seen = 0;
    bit         end_req = 1'b0;
    bit         end_done = 1'b0;
    bit         infl[2] = '{1'b0, 1'b0};
    logic [2:0] st_addr[2];
    int         st_len[2] = '{0, 0};
    logic       prev_g1[2] = '{1'b0, 1'b0};
    logic [2:0] prev_a[2] = '{3'd0, 3'd0};

    function automatic void chk(input string nm, input int k, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)", nm, k, act, expv, $time);
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_A:     return "a";
            S_G1:    return "g1";
            S_NG2A:  return "ng2a";
            S_NG2B:  return "ng2b";
            S_RDY:   return "rdy";
            S_BUSY:  return "busy";
            default: return "done";
        endcase
    endfunction

    function automatic int sig_val(input int s);
        case (s)
            S_A:     return int'(bus0.a);
            S_G1:    return int'(bus0.g1);
            S_NG2A:  return int'(bus0.ng2a);
            S_NG2B:  return int'(bus0.ng2b);
            S_RDY:   return int'(bus0.rdy);
            S_BUSY:  return int'(bus0.busy);
            default: return int'(bus0.done);
        endcase
    endfunction

    // Strobe tracker: enable coherence, A stability, strobe length and order.
    function automatic void track(input int k, input logic rstn, input logic g1, input logic ng2a,
                                  input logic ng2b, input logic [2:0] a, input logic done);
        strobe_t e;
        int      qs;
        if (!rstn) begin
            infl[k]    = 1'b0;
            prev_g1[k] = 1'b0;
            prev_a[k]  = a;
            return;
        end
        chk("ng2a_vs_g1", k, int'(ng2a), int'(!g1));
        chk("ng2b_vs_ng2a", k, int'(ng2b), int'(ng2a));
        if (done) done_cnt[k]++;
        if (g1 && !prev_g1[k]) begin
            chk("a_at_enable_rise", k, int'(a), int'(prev_a[k]));
            infl[k]    = 1'b1;
            st_addr[k] = a;
            st_len[k]  = 1;
        end else if (g1 && prev_g1[k]) begin
            st_len[k]++;
            chk("a_stable_in_strobe", k, int'(a), int'(st_addr[k]));
        end else if (!g1 && prev_g1[k] && infl[k]) begin
            infl[k] = 1'b0;
            chk("a_at_enable_fall", k, int'(a), int'(st_addr[k]));
            qs = (k == 0) ? sb0.size() : sb1.size();
            chk("strobe_expected", k, int'(qs > 0), 1);
            if (qs > 0) begin
                e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("strobe_addr", k, int'(st_addr[k]), int'(e.addr));
                chk("strobe_len", k, st_len[k], e.len);
            end
        end
        prev_g1[k] = g1;
        prev_a[k]  = a;
    endfunction

    // Monitor: point checks, strobe tracking, bound expiries and final drain.
    initial begin
        pchk_t p;
        forever begin
            @(negedge clk);
            while (pchk_q.size() > 0) begin
                p = pchk_q.pop_front();
                chk(sig_name(p.sig), 0, sig_val(p.sig), p.expv);
            end
            track(0, nreset, bus0.g1, bus0.ng2a, bus0.ng2b, bus0.a, bus0.done);
            track(1, nreset, bus1.g1, bus1.ng2a, bus1.ng2b, bus1.a, bus1.done);
            if (tmo_req != tmo_seen) begin
                chk("wait_bound", 0, tmo_req, tmo_seen);
                tmo_seen = tmo_req;
            end
            if (end_req && !end_done) begin
                chk("sb_drained", 0, sb0.size(), 0);
                chk("sb_drained", 1, sb1.size(), 0);
                chk("done_count", 0, done_cnt[0], exp_done[0]);
                chk("done_count", 1, done_cnt[1], exp_done[1]);
                end_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pc(input int s, input int v);
        pchk_t p;
        p.sig  = s;
        p.expv = v;
        pchk_q.push_back(p);
    endtask

    // Present one select on instance 0 for a cycle; record it if it will be strobed.
    task automatic post0(input logic [2:0] s, input int len, input bit strobes);
        strobe_t e;
        bus0.req = 1'b1;
        bus0.sel = s;
        if (bus0.rdy && strobes) begin
            e.addr = s;
            e.len  = len;
            sb0.push_back(e);
            exp_done[0]++;
        end
        step();
        bus0.req = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (((k == 0) ? (bus0.busy || bus0.g1) : (bus1.busy || bus1.g1)) && (n < 300)) begin
            step();
            n++;
        end
        if (n >= 300) tmo_req++;
        step();
        step();
    endtask

    // Stimulus.
    initial begin
        strobe_t e;
        int      n;
        nreset = 1'b0;
        bus0.req = 1'b0; bus0.sel = 3'd0; bus0.abort = 1'b0;
        bus1.req = 1'b0; bus1.sel = 3'd0; bus1.abort = 1'b0;
        step();
        pc(S_A, 0); pc(S_G1, 0); pc(S_NG2A, 1); pc(S_NG2B, 1);
        pc(S_RDY, 1); pc(S_BUSY, 0); pc(S_DONE, 0);
        step();
        nreset = 1'b1;
        step();

        // Reset mid-strobe: enables and A drop without a clock edge.
        post0(3'd4, 2, 1'b0);
        step();
        pc(S_G1, 1);
        step();
        nreset = 1'b0;
        pc(S_G1, 0); pc(S_NG2A, 1); pc(S_NG2B, 1); pc(S_A, 0);
        pc(S_RDY, 1); pc(S_BUSY, 0); pc(S_DONE, 0);
        step();
        step();
        nreset = 1'b1;
        pc(S_RDY, 1); pc(S_BUSY, 0);
        step();

        // Single select, default timing.
        post0(3'd5, 2, 1'b1);
        pc(S_A, 5); pc(S_G1, 0); pc(S_NG2A, 1); pc(S_BUSY, 1); pc(S_RDY, 1);
        step(); pc(S_G1, 1); pc(S_NG2A, 0); pc(S_NG2B, 0); pc(S_A, 5);
        step(); pc(S_G1, 1);
        step(); pc(S_G1, 0); pc(S_NG2A, 1); pc(S_DONE, 0); pc(S_A, 5);
        step(); pc(S_DONE, 1); pc(S_A, 5);
        step(); pc(S_DONE, 0); pc(S_BUSY, 0);
        wait_idle(0);

        // Pending select, different address.
        post0(3'd3, 2, 1'b1);
        step();
        post0(3'd6, 2, 1'b1);
        pc(S_RDY, 0); pc(S_BUSY, 1);
        step(); pc(S_G1, 0); pc(S_A, 3);
        step(); pc(S_A, 6); pc(S_DONE, 1); pc(S_RDY, 1); pc(S_G1, 0);
        wait_idle(0);

        // Pending select, same address: SETUP skipped.
        post0(3'd2, 2, 1'b1);
        step();
        post0(3'd2, 2, 1'b1);
        step(); pc(S_G1, 0); pc(S_DONE, 0);
        step(); pc(S_G1, 1); pc(S_DONE, 1); pc(S_A, 2);
        wait_idle(0);

        // Abort in SETUP: no strobe, no done.
        post0(3'd1, 2, 1'b0);
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        pc(S_G1, 0); pc(S_BUSY, 0);
        step(); pc(S_G1, 0); pc(S_DONE, 0);
        step(); pc(S_DONE, 0);
        wait_idle(0);

        // Abort in SETUP with a same-cycle transfer: the pending select survives.
        post0(3'd1, 2, 1'b0);
        bus0.abort = 1'b1;
        bus0.req   = 1'b1;
        bus0.sel   = 3'd4;
        e.addr = 3'd4;
        e.len  = 2;
        sb0.push_back(e);
        exp_done[0]++;
        step();
        bus0.abort = 1'b0;
        bus0.req   = 1'b0;
        pc(S_RDY, 0); pc(S_BUSY, 1); pc(S_G1, 0);
        step(); pc(S_A, 4); pc(S_RDY, 1);
        wait_idle(0);

        // Abort in the first STROBE cycle: one-cycle strobe, full HOLD, done.
        post0(3'd7, 1, 1'b1);
        step(); pc(S_G1, 1);
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        pc(S_G1, 0); pc(S_NG2A, 1); pc(S_DONE, 0);
        step(); pc(S_DONE, 1);
        wait_idle(0);

        // Abort in HOLD has no effect.
        post0(3'd5, 2, 1'b1);
        step(); step(); step();
        bus0.abort = 1'b1;
        step();
        bus0.abort = 1'b0;
        pc(S_DONE, 1);
        wait_idle(0);

        // Random traffic on the 3/4/2 instance.
        for (int i = 0; i < 400; i++) begin
            bus1.req = ($urandom_range(0, 2) == 0);
            bus1.sel = 3'($urandom_range(0, 3));
            if (bus1.req && bus1.rdy) begin
                e.addr = bus1.sel;
                e.len  = 4;
                sb1.push_back(e);
                exp_done[1]++;
            end
            step();
        end
        bus1.req = 1'b0;
        wait_idle(1);

        end_req = 1'b1;
        n = 0;
        while (!end_done && (n < 10)) begin
            step();
            n++;
        end
        if (!end_done) $display("FAIL end_handshake: monitor did not finish, got 0, expected 1");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
